// File: rtl/dip_led_sequencer_if.sv
// Switch/LED bundle between the board top level and the DIP-to-LED sequencer.
// The slave side is the sequencer: it reads the raw switches and drives the
// LEDs plus the debounced switch view.
interface dip_led_sequencer_if;
    logic [4:1] ckey;        // raw DIP switches, 0 = on, asynchronous to clk
    logic [4:1] LED;         // LED drive, 0 = lit
    logic [4:1] sw_db;       // debounced switch levels, same polarity as ckey
    logic       sw_changed;  // one-cycle pulse when sw_db updates

    modport master (
        output ckey,
        input  LED,
        input  sw_db,
        input  sw_changed
    );

    modport slave (
        input  ckey,
        output LED,
        output sw_db,
        output sw_changed
    );
endinterface

// File: rtl/dip_led_sequencer.sv
// DIP switch to LED sequencer: synchronises and debounces the four switches,
// decodes them into a display mode and a step speed, and drives the LEDs as a
// direct mirror, a left chase, a right chase or an all-on/all-off blink.
module dip_led_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_CYCLES     = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    dip_led_sequencer_if.slave   io
);

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
    // Slowest speed is 8x the base period, so the counter must reach 8*STEP-1.
    localparam int                STEP_W    = $clog2(STEP_CYCLES * 8);
    localparam logic [STEP_W-1:0] STEP_BASE = STEP_W'(STEP_CYCLES);

    typedef enum logic [1:0] {
        ST_DIRECT  = 2'd0,
        ST_CHASE_L = 2'd1,
        ST_CHASE_R = 2'd2,
        ST_BLINK   = 2'd3
    } state_t;

    logic [4:1]        sync1_q, sync2_q;
    logic [4:1]        db_q, db_d;
    logic              chg_q, chg_d;
    logic [DB_W-1:0]   dcnt_q [1:4];
    logic [DB_W-1:0]   dcnt_d [1:4];

    state_t            state_q, state_d;
    logic [1:0]        speed_q, speed_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        pos_q, pos_d;      // lit LED index, 0 = LED1 .. 3 = LED4
    logic              phase_q, phase_d;  // 1 = blink phase with all LEDs lit
    logic [4:1]        led_q, led_d;

    logic [4:1]        sw_on_s;
    state_t            mode_s;
    logic [1:0]        speed_s;
    logic [STEP_W-1:0] period_m1_s;
    logic              restart_s;
    logic              tick_s;

    assign sw_on_s     = ~db_q;
    assign mode_s      = state_t'(sw_on_s[2:1]);
    assign speed_s     = sw_on_s[4:3];
    assign period_m1_s = (STEP_BASE << speed_q) - STEP_W'(1);

    assign io.LED        = led_q;
    assign io.sw_db      = db_q;
    assign io.sw_changed = chg_q;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= io.ckey;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: accept a level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_d  = db_q;
        chg_d = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            dcnt_d[i] = {DB_W{1'b0}};
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DB_MAX) begin
                    db_d[i] = sync2_q[i];
                    chg_d   = 1'b1;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DB_W'(1);
                end
            end else begin
                dcnt_d[i] = {DB_W{1'b0}};
            end
        end
    end

    // Debounce state, debounced levels and the change pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q  <= 4'b1111;
            chg_q <= 1'b0;
            for (int i = 1; i <= 4; i++) begin
                dcnt_q[i] <= {DB_W{1'b0}};
            end
        end else begin
            db_q  <= db_d;
            chg_q <= chg_d;
            for (int i = 1; i <= 4; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    // Mode/speed tracking, step timer and pattern position; a restart outranks a tick.
    always_comb begin
        state_d   = mode_s;
        speed_d   = speed_s;
        step_d    = step_q;
        pos_d     = pos_q;
        phase_d   = phase_q;
        tick_s    = 1'b0;
        restart_s = (mode_s != state_q) || (speed_s != speed_q);
        if (restart_s) begin
            step_d  = {STEP_W{1'b0}};
            pos_d   = (mode_s == ST_CHASE_R) ? 2'd3 : 2'd0;
            phase_d = 1'b1;
        end else begin
            case (state_q)
                ST_CHASE_L, ST_CHASE_R, ST_BLINK: begin
                    if (step_q == period_m1_s) begin
                        step_d = {STEP_W{1'b0}};
                        tick_s = 1'b1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
                default: step_d = {STEP_W{1'b0}};
            endcase
            if (tick_s) begin
                case (state_q)
                    ST_CHASE_L: pos_d   = pos_q + 2'd1;
                    ST_CHASE_R: pos_d   = pos_q - 2'd1;
                    ST_BLINK:   phase_d = ~phase_q;
                    default:    pos_d   = pos_q;
                endcase
            end else begin
                pos_d = pos_q;
            end
        end
    end

    // LED pattern for the current state, registered on the next edge.
    always_comb begin
        led_d = 4'b1111;
        case (state_q)
            ST_DIRECT:  led_d = db_q;
            ST_CHASE_L: led_d = ~(4'b0001 << pos_q);
            ST_CHASE_R: led_d = ~(4'b0001 << pos_q);
            ST_BLINK:   led_d = phase_q ? 4'b0000 : 4'b1111;
            default:    led_d = 4'b1111;
        endcase
    end

    // Sequencer state register and registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DIRECT;
            speed_q <= 2'd0;
            step_q  <= {STEP_W{1'b0}};
            pos_q   <= 2'd0;
            phase_q <= 1'b1;
            led_q   <= 4'b1111;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            step_q  <= step_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: doc/dip_led_sequencer.md
Name: dip_led_sequencer

Overview:
Controller between the 4-position DIP switch bank and the 4 board LEDs.
- Synchronises and debounces the switches.
- Decodes them into a display mode and a speed.
- Sequences the LEDs: direct mirror, chase left, chase right or blink.
- Replaces the direct switch-to-LED wiring on the board top level.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a switch change (20 ms at 50 MHz); minimum 2.
STEP_CYCLES, 12500000, base pattern step period in clk cycles (250 ms at 50 MHz); minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous reset, active-high.
ckey  input  [4:1]  raw DIP switches; 0 = switch on, 1 = off; asynchronous to clk.
LED  output  [4:1]  LED drive, registered; 0 = lit, 1 = dark.
sw_db  output  [4:1]  debounced switch levels, same polarity as ckey.
sw_changed  output  1  one-cycle pulse when any sw_db bit updates.

Behaviour:
Reset (asynchronous, active-high):
- LED=4'b1111, sw_db=4'b1111, sw_changed=0.
- Synchroniser flops = 1; state DIRECT; step counter 0; chase position 0.

Synchronisation and debounce:
- ckey passes through a 2-flop synchroniser per bit.
- Per bit, a counter runs while the synced bit != sw_db bit, and clears to 0 whenever they match.
- When a counter reaches DEBOUNCE_CYCLES-1 and the bit still differs:
  - that sw_db bit takes the synced value on that edge;
  - sw_changed=1 for exactly 1 cycle (one pulse even if several bits update together);
  - the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches sw_db.

Decode (sw_on = ~sw_db):
- Mode = sw_on[2:1]: 0 DIRECT, 1 CHASE_L, 2 CHASE_R, 3 BLINK.
- Speed = sw_on[4:3]: step period P = STEP_CYCLES << speed, i.e. 1x, 2x, 4x or 8x. Counter width must hold STEP_CYCLES*8-1.

State machine (states DIRECT, CHASE_L, CHASE_R, BLINK):
- The state follows the decoded mode and changes on the edge after sw_db changes.
- On any mode or speed change: step counter := 0; CHASE_L position := LED1; CHASE_R position := LED4; BLINK phase := lit.
- Step tick: the counter counts 0..P-1, wraps, and asserts tick on the wrap edge. The counter runs only in the CHASE and BLINK states and is held at 0 in DIRECT.
- DIRECT: LED = sw_db, i.e. a switch that is on lights its LED.
- CHASE_L: exactly one LED lit. Each tick advances LED1->LED2->LED3->LED4->LED1.
- CHASE_R: exactly one LED lit. Each tick advances LED4->LED3->LED2->LED1->LED4.
- BLINK: all LEDs lit, then all dark; toggles each tick.

Output timing:
- LED is registered one cycle after the state, position or phase, and after sw_db in DIRECT.
- First pattern frame after a mode change appears 2 cycles after the sw_db update; each step change follows its tick by 1 cycle.
- Raw ckey edge to sw_db update: 2 + DEBOUNCE_CYCLES cycles.
- Raw ckey edge to LED in DIRECT: 2 + DEBOUNCE_CYCLES + 1 cycles.

Boundary conditions:
- Simultaneous mode and speed change: one restart.
- Switch toggled back before debounce completes: no change, no pulse.
- Reset mid-pattern: LED goes dark immediately, asynchronously. After release the block starts in DIRECT, with sw_db re-qualified from 1111 through the normal debounce.
- Tick on the same edge as a mode change: the mode restart wins and the tick is discarded.

Test Plan:
Use DEBOUNCE_CYCLES=4 and STEP_CYCLES=3 throughout.
1. Assert rst with ckey=1111 -> LED=1111, sw_db=1111, sw_changed=0; release -> outputs unchanged for 50 cycles.
2. ckey 1111->0111 -> sw_db=0111 exactly 6 cycles later, with a 1-cycle sw_changed pulse; LED=0111 one cycle after that (DIRECT, speed 2 ignored).
3. In DIRECT, pulse ckey[4] low for 3 cycles, then back high -> sw_db, LED and sw_changed unchanged.
4. ckey=1110 (CHASE_L, speed 0) -> LED sequence 1110, 1101, 1011, 0111, 1110, each held 3 cycles.
5. ckey=1001 (CHASE_R, speed 1) -> LED sequence 0111, 1011, 1101, 1110, 0111, each held 6 cycles. Changing to ckey=1101 mid-sequence restarts at 0111 with 3-cycle steps.
6. ckey=1100 (BLINK) -> LED alternates 0000 and 1111 every 3 cycles. Asserting rst during a 0000 phase -> LED=1111 before the next clk edge.
